traffic_phase_ctrl: RTL and testbench
=====================================

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 Parameter CNT_W, 8, phase timer width in bits.
REQ-002 Parameter HG_MIN, 30, minimum highway green, in ticks.
REQ-003 Parameter Y_T, 5, yellow duration for either road, in ticks.
REQ-004 Parameter AR_T, 1, all-red clearance duration, in ticks.
REQ-005 Parameter FG_MIN, 5, minimum farm green, in ticks.
REQ-006 Parameter FG_MAX, 20, maximum farm green, in ticks.
REQ-007 Port list, in order:
- Clk  in  1  single clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high reset.
- Tick  in  1  one-cycle timing enable (e.g. 1 Hz strobe).
- Sensor  in  1  farm-road vehicle present, level.
- PedReq  in  1  pedestrian button, one-cycle pulse.
- Hy  out  2  highway light.
- Fr  out  2  farm light.
- State  out  3  current phase code.
- Count  out  CNT_W  ticks elapsed in the current phase.
- Walk  out  1  pedestrian walk lamp.
- PedPending  out  1  pedestrian request latched.

Function
REQ-008 Light codes SHALL be G=2'd0, Y=2'd1, R=2'd2; 2'd3 is never driven.
REQ-009 Phase codes SHALL be:
- HG=0: Hy G, Fr R.
- HY=1: Hy Y, Fr R.
- AR1=2: Hy R, Fr R.
- FG=3: Hy R, Fr G.
- FY=4: Hy R, Fr Y.
- AR2=5: Hy R, Fr R.
- Codes 6 and 7 SHALL recover to HG on the next clock.
REQ-010 All outputs SHALL be registered or decoded only from registered state; no input-to-output combinational path.
REQ-011 State, Count and PedPending SHALL change only on a Tick cycle, with one exception: a PedReq capture (REQ-017) SHALL set PedPending on any cycle.
REQ-012 On a Tick cycle without a transition, Count SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-013 On a transition, Count SHALL become 0 in the same edge as the State update.
REQ-014 Phase transitions, evaluated only on a Tick cycle using Sensor and PedPending sampled that cycle:
- HG->HY when Count>=HG_MIN-1 and (Sensor or PedPending).
- HY->AR1 when Count==Y_T-1.
- AR1->FG when Count==AR_T-1.
- FG->FY when (Count>=FG_MIN-1 and Sensor==0) or Count==FG_MAX-1.
- FY->AR2 when Count==Y_T-1.
- AR2->HG when Count==AR_T-1.
REQ-015 HG SHALL hold indefinitely without a request; Count saturates per REQ-012 and the phase does not wrap.
REQ-016 Sensor SHALL NOT be latched; a Sensor pulse that has dropped before the qualifying HG Tick SHALL cause no transition.
REQ-017 PedReq SHALL set PedPending on the next edge in every phase except FG; PedReq in FG SHALL be ignored.
REQ-018 PedPending SHALL clear on the edge that enters FG; if PedReq is also high that cycle, the clear wins.
REQ-019 Walk SHALL be 1 exactly while State==FG.
REQ-020 Legal parameters: all durations >=1; FG_MAX>=FG_MIN; every duration <=2^CNT_W-1. Other values are unsupported.

Reset
REQ-021 Reset high at a posedge SHALL force State=HG, Count=0, PedPending=0, Walk=0, Hy=G, Fr=R, overriding Tick, Sensor and PedReq that cycle.
REQ-022 Reset SHALL be honoured in any phase, including mid-yellow and mid-FG, with no clearance sequence.

Verification
REQ-023 Idle: defaults, Tick=1, Sensor=0, PedReq=0 for 300 cycles -> State=0 throughout; Count reaches 255 and holds.
REQ-024 Max-out: Sensor=1 from reset, Tick=1 -> dwell is HG 30, HY 5, AR1 1, FG 20, FY 5, AR2 1 cycles; State=0 again at cycle 62.
REQ-025 Sensor glitch: Sensor=1 only at cycle 10, Tick=1 -> no transition; Sensor=1 at cycle 29 -> HY at cycle 30.
REQ-026 Pedestrian: PedReq pulse at cycle 3, Sensor=0, Tick=1 -> PedPending=1 from cycle 4; FG entered at cycle 36 with PedPending=0 and Walk=1; gap-out to FY after 5 cycles.
REQ-027 Mid-phase reset: Reset at FG Count=7 -> next cycle State=0, Count=0, Walk=0, Hy=G, Fr=R.
REQ-028 Tick gating: Tick=0 for 100 cycles in HY with Count=2 -> State and Count unchanged; a PedReq in that window still sets PedPending.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
// Highway/farm-road intersection phase controller with pedestrian walk phase.
// Lights and Walk decode from the registered phase; timing advances on Tick.
module traffic_phase_ctrl #(
    parameter int CNT_W  = 8,
    parameter int HG_MIN = 30,
    parameter int Y_T    = 5,
    parameter int AR_T   = 1,
    parameter int FG_MIN = 5,
    parameter int FG_MAX = 20
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Tick,
    input  logic             Sensor,
    input  logic             PedReq,
    output logic [1:0]       Hy,
    output logic [1:0]       Fr,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] Count,
    output logic             Walk,
    output logic             PedPending
);

    typedef enum logic [2:0] {
        S_HG  = 3'd0,
        S_HY  = 3'd1,
        S_AR1 = 3'd2,
        S_FG  = 3'd3,
        S_FY  = 3'd4,
        S_AR2 = 3'd5
    } phase_t;

    localparam logic [1:0] L_G = 2'd0;
    localparam logic [1:0] L_Y = 2'd1;
    localparam logic [1:0] L_R = 2'd2;

    // Last count value of each timed phase (duration - 1)
    localparam logic [CNT_W-1:0] HG_LAST = CNT_W'(HG_MIN - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(Y_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(AR_T - 1);
    localparam logic [CNT_W-1:0] FGN_LAST = CNT_W'(FG_MIN - 1);
    localparam logic [CNT_W-1:0] FGX_LAST = CNT_W'(FG_MAX - 1);

    phase_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_ped;

    phase_t w_state_nx;
    logic   w_go;
    logic   w_bad;

    always_comb begin
        w_state_nx = r_state;
        w_go       = 1'b0;
        w_bad      = 1'b0;
        case (r_state)
            S_HG: begin
                w_go       = (r_count >= HG_LAST) && (Sensor || r_ped);
                w_state_nx = S_HY;
            end
            S_HY: begin
                w_go       = (r_count == Y_LAST);
                w_state_nx = S_AR1;
            end
            S_AR1: begin
                w_go       = (r_count == AR_LAST);
                w_state_nx = S_FG;
            end
            S_FG: begin
                w_go       = ((r_count >= FGN_LAST) && !Sensor) || (r_count == FGX_LAST);
                w_state_nx = S_FY;
            end
            S_FY: begin
                w_go       = (r_count == Y_LAST);
                w_state_nx = S_AR2;
            end
            S_AR2: begin
                w_go       = (r_count == AR_LAST);
                w_state_nx = S_HG;
            end
            default: begin
                w_bad      = 1'b1;
                w_state_nx = S_HG;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_HG;
            r_count <= '0;
            r_ped   <= 1'b0;
        end else begin
            // Illegal codes recover immediately, independent of Tick
            if (w_bad) begin
                r_state <= S_HG;
                r_count <= '0;
            end else if (Tick) begin
                if (w_go) begin
                    r_state <= w_state_nx;
                    r_count <= '0;
                end else if (r_count != '1) begin
                    r_count <= r_count + 1'b1;
                end
            end
            // Entering FG serves the request; that clear beats a same-cycle press
            if (Tick && w_go && !w_bad && (w_state_nx == S_FG))
                r_ped <= 1'b0;
            else if (PedReq && (r_state != S_FG))
                r_ped <= 1'b1;
        end
    end

    always_comb begin
        Hy = L_R;
        Fr = L_R;
        case (r_state)
            S_HG:    Hy = L_G;
            S_HY:    Hy = L_Y;
            S_FG:    Fr = L_G;
            S_FY:    Fr = L_Y;
            default: begin
                Hy = L_R;
                Fr = L_R;
            end
        endcase
    end

    assign State      = r_state;
    assign Count      = r_count;
    assign Walk       = (r_state == S_FG);
    assign PedPending = r_ped;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl; cycle n = state seen after n edges past reset.
module tb_traffic_phase_ctrl;

    logic       Clk = 1'b0;
    logic       Reset, Tick, Sensor, PedReq;
    logic [1:0] Hy, Fr;
    logic [2:0] State;
    logic [7:0] Count;
    logic       Walk, PedPending;

    int checks = 0;
    int errors = 0;

    traffic_phase_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Tick(Tick), .Sensor(Sensor), .PedReq(PedReq),
        .Hy(Hy), .Fr(Fr), .State(State), .Count(Count), .Walk(Walk),
        .PedPending(PedPending)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    // Expected phase for the max-out schedule (Sensor held high)
    function automatic int sched_state(input int c);
        if (c < 30) return 0;
        if (c < 35) return 1;
        if (c == 35) return 2;
        if (c < 56) return 3;
        if (c < 61) return 4;
        if (c == 61) return 5;
        return 0;
    endfunction

    function automatic int sched_start(input int c);
        if (c < 30) return 0;
        if (c < 35) return 30;
        if (c == 35) return 35;
        if (c < 56) return 36;
        if (c < 61) return 56;
        if (c == 61) return 61;
        return 62;
    endfunction

    task automatic test_reset();
        Tick = 1'b1; Sensor = 1'b1; PedReq = 1'b1;
        do_reset();
        Tick = 1'b0; Sensor = 1'b0; PedReq = 1'b0;
        checks++;
        if (State !== 3'd0 || Count !== 8'd0 || PedPending !== 1'b0 || Walk !== 1'b0 ||
            Hy !== 2'd0 || Fr !== 2'd2) begin
            errors++;
            $display("FAIL reset: State=%0d Count=%0d Ped=%0b Walk=%0b Hy=%0d Fr=%0d, want 0 0 0 0 0 2",
                     State, Count, PedPending, Walk, Hy, Fr);
        end
    endtask

    task automatic test_idle();
        int e;
        Tick = 1'b1; Sensor = 1'b0; PedReq = 1'b0;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            e = (c > 255) ? 255 : c;
            checks++;
            if (State !== 3'd0 || Count !== 8'(e) || Hy !== 2'd0 || Fr !== 2'd2) begin
                errors++;
                $display("FAIL idle c=%0d: State=%0d Count=%0d, want 0 %0d", c, State, Count, e);
            end
            step();
        end
    endtask

    task automatic test_maxout();
        int es;
        logic [1:0] ehy, efr;
        Tick = 1'b1; Sensor = 1'b1; PedReq = 1'b0;
        do_reset();
        for (int c = 0; c <= 62; c++) begin
            es  = sched_state(c);
            ehy = (es == 0) ? 2'd0 : (es == 1) ? 2'd1 : 2'd2;
            efr = (es == 3) ? 2'd0 : (es == 4) ? 2'd1 : 2'd2;
            checks++;
            if (State !== 3'(es) || Count !== 8'(c - sched_start(c)) || Hy !== ehy ||
                Fr !== efr || Walk !== (es == 3)) begin
                errors++;
                $display("FAIL maxout c=%0d: State=%0d Count=%0d Hy=%0d Fr=%0d Walk=%0b, want %0d %0d %0d %0d %0b",
                         c, State, Count, Hy, Fr, Walk, es, c - sched_start(c), ehy, efr, es == 3);
            end
            step();
        end
    endtask

    task automatic test_glitch();
        Tick = 1'b1; Sensor = 1'b0; PedReq = 1'b0;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            Sensor = (c == 10 || c == 29);
            checks++;
            if (State !== 3'd0) begin
                errors++;
                $display("FAIL glitch c=%0d: State=%0d, want 0", c, State);
            end
            step();
        end
        Sensor = 1'b0;
        checks++;
        if (State !== 3'd1 || Count !== 8'd0) begin
            errors++;
            $display("FAIL glitch_hy: State=%0d Count=%0d, want 1 0", State, Count);
        end
    endtask

    task automatic test_ped();
        Tick = 1'b1; Sensor = 1'b0; PedReq = 1'b0;
        do_reset();
        for (int c = 0; c < 42; c++) begin
            // Pulse at 3 latches; press at 35 collides with FG entry; press at 37 is in FG
            PedReq = (c == 3 || c == 35 || c == 37);
            if (c == 3 || c == 4) begin
                checks++;
                if (PedPending !== (c == 4)) begin
                    errors++;
                    $display("FAIL ped_latch c=%0d: PedPending=%0b, want %0b", c, PedPending, c == 4);
                end
            end
            if (c == 29 || c == 30) begin
                checks++;
                if (State !== 3'(c - 29)) begin
                    errors++;
                    $display("FAIL ped_hy c=%0d: State=%0d, want %0d", c, State, c - 29);
                end
            end
            if (c >= 36 && c <= 40) begin
                checks++;
                if (State !== 3'd3 || Walk !== 1'b1 || PedPending !== 1'b0) begin
                    errors++;
                    $display("FAIL ped_fg c=%0d: State=%0d Walk=%0b Ped=%0b, want 3 1 0",
                             c, State, Walk, PedPending);
                end
            end
            if (c == 41) begin
                checks++;
                if (State !== 3'd4 || Walk !== 1'b0 || PedPending !== 1'b0) begin
                    errors++;
                    $display("FAIL ped_gapout: State=%0d Walk=%0b Ped=%0b, want 4 0 0",
                             State, Walk, PedPending);
                end
            end
            step();
        end
        PedReq = 1'b0;
    endtask

    task automatic test_mid_reset();
        Tick = 1'b1; Sensor = 1'b1; PedReq = 1'b0;
        do_reset();
        repeat (43) step();
        checks++;
        if (State !== 3'd3 || Count !== 8'd7) begin
            errors++;
            $display("FAIL midrst_pre: State=%0d Count=%0d, want 3 7", State, Count);
        end
        PedReq = 1'b1;
        do_reset();
        PedReq = 1'b0;
        checks++;
        if (State !== 3'd0 || Count !== 8'd0 || Walk !== 1'b0 || Hy !== 2'd0 ||
            Fr !== 2'd2 || PedPending !== 1'b0) begin
            errors++;
            $display("FAIL midrst: State=%0d Count=%0d Walk=%0b Hy=%0d Fr=%0d Ped=%0b, want 0 0 0 0 2 0",
                     State, Count, Walk, Hy, Fr, PedPending);
        end
    endtask

    task automatic test_tick_gate();
        Tick = 1'b1; Sensor = 1'b1; PedReq = 1'b0;
        do_reset();
        repeat (32) step();
        checks++;
        if (State !== 3'd1 || Count !== 8'd2) begin
            errors++;
            $display("FAIL gate_pre: State=%0d Count=%0d, want 1 2", State, Count);
        end
        Tick = 1'b0;
        for (int i = 0; i < 100; i++) begin
            PedReq = (i == 50);
            step();
            checks++;
            if (State !== 3'd1 || Count !== 8'd2 || PedPending !== (i >= 50)) begin
                errors++;
                $display("FAIL gate i=%0d: State=%0d Count=%0d Ped=%0b, want 1 2 %0b",
                         i, State, Count, PedPending, i >= 50);
            end
        end
        PedReq = 1'b0;
        Tick = 1'b1;
        step();
        checks++;
        if (State !== 3'd1 || Count !== 8'd3) begin
            errors++;
            $display("FAIL gate_resume: State=%0d Count=%0d, want 1 3", State, Count);
        end
    endtask

    initial begin
        Reset = 1'b1; Tick = 1'b0; Sensor = 1'b0; PedReq = 1'b0;
        test_reset();
        test_idle();
        test_maxout();
        test_glitch();
        test_ped();
        test_mid_reset();
        test_tick_gate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
